// File: rtl/fifo_multi_push_pop.sv
// Multi-port FIFO: up to P compacted pushes and up to Q pops per cycle, single clock.
// Pushes are all-or-nothing against the pre-edge occupancy; pops are registered with one cycle of latency.
module fifo_multi_push_pop #(
  parameter int W         = 32,
  parameter int P         = 4,
  parameter int Q         = 2,
  parameter int D         = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [P-1:0]             push_vld,
  input  logic [P*W-1:0]           push_data,
  input  logic [$clog2(Q+1)-1:0]   pop_cnt,
  output logic [Q-1:0]             pop_valid_r,
  output logic [Q*W-1:0]           pop_data_r,
  output logic                     push_ovf_r,
  output logic                     empty_r,
  output logic                     full_r,
  output logic                     almost_full_r,
  output logic [$clog2(D+1)-1:0]   count_r
);

  localparam int AW  = $clog2(D);
  localparam int CW  = $clog2(D+1);
  localparam int PCW = $clog2(Q+1);

  logic [W-1:0]  mem_r [D];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;

  logic [CW-1:0] k_s;
  logic [AW-1:0] off_s [P];
  logic [AW-1:0] run_s;
  logic          accept_s;
  logic [CW-1:0] req_s;
  logic [CW-1:0] m_s;
  logic [CW-1:0] add_s;
  logic [CW-1:0] cnt_next_s;
  logic [W-1:0]  rd_data_s [Q];

  // Push popcount, per-port compaction offsets, acceptance and pop size.
  always_comb begin
    k_s   = {CW{1'b0}};
    run_s = {AW{1'b0}};
    for (int i = 0; i < P; i++) begin
      off_s[i] = run_s;
      run_s    = run_s + AW'(push_vld[i]);
      k_s      = k_s + CW'(push_vld[i]);
    end

    accept_s = (k_s <= (CW'(D) - count_r));
    if (accept_s) begin
      add_s = k_s;
    end else begin
      add_s = {CW{1'b0}};
    end

    if (pop_cnt > PCW'(Q)) begin
      req_s = CW'(Q);
    end else begin
      req_s = CW'(pop_cnt);
    end
    if (req_s < count_r) begin
      m_s = req_s;
    end else begin
      m_s = count_r;
    end

    cnt_next_s = count_r + add_s - m_s;

    for (int j = 0; j < Q; j++) begin
      rd_data_s[j] = mem_r[rd_ptr_r + AW'(j)];
    end
  end

  // Storage write: valid ports land at consecutive slots from wr_ptr, wrapping mod D.
  always_ff @(posedge clk) begin
    for (int i = 0; i < P; i++) begin
      if (!rst && accept_s && push_vld[i]) begin
        mem_r[wr_ptr_r + off_s[i]] <= push_data[i*W +: W];
      end
    end
  end

  // Pointers, occupancy, status flags and registered pop lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      empty_r       <= 1'b1;
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      push_ovf_r    <= 1'b0;
      pop_valid_r   <= {Q{1'b0}};
      pop_data_r    <= {(Q*W){1'b0}};
    end else begin
      wr_ptr_r      <= wr_ptr_r + AW'(add_s);
      rd_ptr_r      <= rd_ptr_r + AW'(m_s);
      count_r       <= cnt_next_s;
      empty_r       <= (cnt_next_s == {CW{1'b0}});
      full_r        <= (cnt_next_s == CW'(D));
      almost_full_r <= (cnt_next_s >= CW'(AF_THRESH));
      push_ovf_r    <= ~accept_s;
      for (int j = 0; j < Q; j++) begin
        pop_valid_r[j] <= (CW'(j) < m_s);
        // Lanes beyond the pop size keep their previous data.
        if (CW'(j) < m_s) begin
          pop_data_r[j*W +: W] <= rd_data_s[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_multi_push_pop.sv
// Directed bench for fifo_multi_push_pop with default parameters (W=32, P=4, Q=2, D=16, AF=12).
module tb_fifo_multi_push_pop;

  logic         clk;
  logic         rst;
  logic [3:0]   push_vld;
  logic [127:0] push_data;
  logic [1:0]   pop_cnt;
  logic [1:0]   pop_valid_r;
  logic [63:0]  pop_data_r;
  logic         push_ovf_r;
  logic         empty_r;
  logic         full_r;
  logic         almost_full_r;
  logic [4:0]   count_r;

  int n_assert;
  int n_fail;

  fifo_multi_push_pop dut (
    .clk(clk), .rst(rst), .push_vld(push_vld), .push_data(push_data), .pop_cnt(pop_cnt),
    .pop_valid_r(pop_valid_r), .pop_data_r(pop_data_r), .push_ovf_r(push_ovf_r),
    .empty_r(empty_r), .full_r(full_r), .almost_full_r(almost_full_r), .count_r(count_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [3:0] vld, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    push_vld  = vld;
    push_data = {d3, d2, d1, d0};
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    push_vld  = 4'b0000;
    push_data = 128'h0;
    pop_cnt   = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count", 64'(count_r), 64'd0);
    chk("rst_empty", 64'(empty_r), 64'd1);
    chk("rst_full", 64'(full_r), 64'd0);
    chk("rst_af", 64'(almost_full_r), 64'd0);
    chk("rst_valid", 64'(pop_valid_r), 64'd0);
    chk("rst_ovf", 64'(push_ovf_r), 64'd0);
    chk("rst_data", pop_data_r, 64'd0);

    // Sparse push 1010 compacts port1 then port3
    set_push(4'b1010, 32'h0, 32'hA1, 32'h0, 32'hA3);
    step();
    chk("sparse_count", 64'(count_r), 64'd2);
    chk("sparse_empty", 64'(empty_r), 64'd0);
    set_push(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    pop_cnt = 2'd2;
    step();
    chk("sparse_valid", 64'(pop_valid_r), 64'd3);
    chk("sparse_lane0", 64'(pop_data_r[31:0]), 64'hA1);
    chk("sparse_lane1", 64'(pop_data_r[63:32]), 64'hA3);
    chk("sparse_cnt0", 64'(count_r), 64'd0);
    chk("sparse_empty1", 64'(empty_r), 64'd1);
    pop_cnt = 2'd0;
    step();
    chk("idle_valid", 64'(pop_valid_r), 64'd0);
    chk("idle_hold", 64'(pop_data_r[31:0]), 64'hA1);

    // Fill with 0..15, four per cycle
    for (int c = 0; c < 4; c++) begin
      set_push(4'b1111, 32'(4*c), 32'(4*c+1), 32'(4*c+2), 32'(4*c+3));
      step();
      chk("fill_count", 64'(count_r), 64'(4*(c+1)));
      chk("fill_af", 64'(almost_full_r), (c >= 2) ? 64'd1 : 64'd0);
      chk("fill_full", 64'(full_r), (c == 3) ? 64'd1 : 64'd0);
      chk("fill_ovf", 64'(push_ovf_r), 64'd0);
    end
    set_push(4'b0001, 32'h99, 32'h0, 32'h0, 32'h0);
    step();
    chk("ovf_pulse", 64'(push_ovf_r), 64'd1);
    chk("ovf_count", 64'(count_r), 64'd16);
    set_push(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk("ovf_clear", 64'(push_ovf_r), 64'd0);
    chk("ovf_count2", 64'(count_r), 64'd16);

    // Drop to 15, then reject a 2-entry push while popping 2
    pop_cnt = 2'd1;
    step();
    chk("p1_valid", 64'(pop_valid_r), 64'd1);
    chk("p1_lane0", 64'(pop_data_r[31:0]), 64'd0);
    chk("p1_count", 64'(count_r), 64'd15);
    chk("p1_full", 64'(full_r), 64'd0);
    set_push(4'b0011, 32'h77, 32'h78, 32'h0, 32'h0);
    pop_cnt = 2'd2;
    step();
    chk("rej_ovf", 64'(push_ovf_r), 64'd1);
    chk("rej_count", 64'(count_r), 64'd13);
    chk("rej_valid", 64'(pop_valid_r), 64'd3);
    chk("rej_lane0", 64'(pop_data_r[31:0]), 64'd1);
    chk("rej_lane1", 64'(pop_data_r[63:32]), 64'd2);
    chk("rej_af", 64'(almost_full_r), 64'd1);

    // Drain 3..14, leaving entry 15 alone
    set_push(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("drain_lane0", 64'(pop_data_r[31:0]), 64'(3 + 2*i));
      chk("drain_lane1", 64'(pop_data_r[63:32]), 64'(4 + 2*i));
    end
    chk("drain_count", 64'(count_r), 64'd1);
    chk("drain_af", 64'(almost_full_r), 64'd0);
    step();
    chk("short_valid", 64'(pop_valid_r), 64'd1);
    chk("short_lane0", 64'(pop_data_r[31:0]), 64'd15);
    chk("short_lane1_hold", 64'(pop_data_r[63:32]), 64'd14);
    chk("short_count", 64'(count_r), 64'd0);
    chk("short_empty", 64'(empty_r), 64'd1);

    // Move pointers from 2 to 14; pop_cnt=3 is clamped to 2
    pop_cnt = 2'd0;
    for (int c = 0; c < 3; c++) begin
      set_push(4'b1111, 32'(32+4*c), 32'(33+4*c), 32'(34+4*c), 32'(35+4*c));
      step();
    end
    chk("adv_count", 64'(count_r), 64'd12);
    set_push(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    pop_cnt = 2'd3;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("clamp_valid", 64'(pop_valid_r), 64'd3);
      chk("clamp_lane0", 64'(pop_data_r[31:0]), 64'(32 + 2*i));
      chk("clamp_lane1", 64'(pop_data_r[63:32]), 64'(33 + 2*i));
    end
    chk("clamp_count", 64'(count_r), 64'd0);

    // Wrap: push 0x10..0x13 across slots 14,15,0,1
    pop_cnt = 2'd0;
    set_push(4'b1111, 32'h10, 32'h11, 32'h12, 32'h13);
    step();
    chk("wrap_count", 64'(count_r), 64'd4);
    set_push(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    pop_cnt = 2'd2;
    step();
    chk("wrap_a0", 64'(pop_data_r[31:0]), 64'h10);
    chk("wrap_a1", 64'(pop_data_r[63:32]), 64'h11);
    step();
    chk("wrap_b0", 64'(pop_data_r[31:0]), 64'h12);
    chk("wrap_b1", 64'(pop_data_r[63:32]), 64'h13);
    chk("wrap_count0", 64'(count_r), 64'd0);

    // Build count 9 with pop_valid 11, then reset between edges
    pop_cnt = 2'd0;
    set_push(4'b1111, 32'h40, 32'h41, 32'h42, 32'h43);
    step();
    set_push(4'b1111, 32'h44, 32'h45, 32'h46, 32'h47);
    step();
    set_push(4'b0111, 32'h48, 32'h49, 32'h4A, 32'h0);
    step();
    chk("pre_count", 64'(count_r), 64'd11);
    set_push(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    pop_cnt = 2'd2;
    step();
    chk("pre_count9", 64'(count_r), 64'd9);
    chk("pre_valid", 64'(pop_valid_r), 64'd3);
    chk("pre_lane0", 64'(pop_data_r[31:0]), 64'h40);
    pop_cnt = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(pop_valid_r), 64'd0);
    chk("arst_count", 64'(count_r), 64'd0);
    chk("arst_empty", 64'(empty_r), 64'd1);
    chk("arst_data", pop_data_r, 64'd0);
    #2;
    rst = 1'b0;
    chk("post_empty", 64'(empty_r), 64'd1);
    set_push(4'b0001, 32'h55, 32'h0, 32'h0, 32'h0);
    step();
    chk("post_count", 64'(count_r), 64'd1);
    set_push(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    pop_cnt = 2'd1;
    step();
    chk("post_valid", 64'(pop_valid_r), 64'd1);
    chk("post_lane0", 64'(pop_data_r[31:0]), 64'h55);
    chk("post_count0", 64'(count_r), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_multi_push_pop.md
Name: fifo_multi_push_pop

Overview:
- Parametrised multi-port FIFO: up to P pushes and up to Q pops per cycle, single clock.
- Successor to the fixed 4-push / 1-pop FIFO.
- Adds:
  - configurable push/pop port counts and depth;
  - sparse push vectors, compacted in port order;
  - all-or-nothing push acceptance with overflow flag;
  - multi-entry pops;
  - occupancy count and almost-full status.
- Used wherever several producers retire into one ordered queue consumed by a multi-lane consumer.

Parameters:
- W, 32, data width per entry.
- P, 4, number of push ports (>=1).
- Q, 2, number of pop lanes (>=1).
- D, 16, total capacity in entries (power of two, D >= max(P,Q)).
- AF_THRESH, 12, almost_full_r asserts when count >= AF_THRESH (1..D).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- push_vld  in  P  per-port push request; any bit pattern is legal.
- push_data  in  P*W  port i data at [i*W +: W].
- pop_cnt  in  $clog2(Q+1)  number of entries requested this cycle (0..Q); values > Q are treated as Q.
- pop_valid_r  out  Q  thermometer code (lane 0 first) of lanes carrying valid data.
- pop_data_r  out  Q*W  lane j data at [j*W +: W].
- push_ovf_r  out  1  one-cycle pulse: the previous cycle's push was rejected.
- empty_r  out  1  count == 0.
- full_r  out  1  count == D.
- almost_full_r  out  1  count >= AF_THRESH.
- count_r  out  $clog2(D+1)  current occupancy.

Interface (already decided):
- One clock, clk.
- Reset is rst: asynchronous, active-high.
- All state clears on the assertion of rst. Normal operation resumes on the first clk edge after deassertion.

Behaviour:

Reset values:
- rd_ptr = wr_ptr = 0, count_r = 0.
- empty_r = 1, full_r = 0, almost_full_r = 0 (unless AF_THRESH == 0, which is illegal).
- pop_valid_r = 0, push_ovf_r = 0, pop_data_r = 0.
- Storage contents are not reset.
- Reset mid-operation discards all entries and any in-flight pop result.

Push, evaluated each cycle using the pre-edge count_r:
- k = popcount(push_vld).
- Accepted iff k <= D - count_r. Acceptance never considers same-cycle pops; there is no pop-to-push credit bypass.
- If accepted:
  - valid ports are written in ascending port index, gaps compacted: the lowest-index valid port goes to wr_ptr, the next to wr_ptr+1, and so on.
  - wr_ptr advances by k, mod D.
- If rejected:
  - no entry is written and wr_ptr is unchanged.
  - push_ovf_r = 1 on the next cycle.
- k == 0 is always accepted and writes nothing.

Pop:
- m = min(pop_cnt, count_r, Q), using the pre-edge count_r.
- Lane j (j < m) receives entry rd_ptr+j, mod D.
- rd_ptr advances by m, mod D.
- Registered output, latency 1:
  - pop_valid_r = (1<<m)-1 and pop_data_r are updated at the same edge.
  - Lanes >= m hold their previous data values; their valid bits are 0.
- Entries pushed at edge t are poppable at the earliest in the cycle after t; there is no write-to-read bypass.

Count and status:
- count_r(next) = count_r + (accepted ? k : 0) - m.
- Pointer arithmetic is in $clog2(D) bits with natural wrap. count_r disambiguates full from empty.
- empty_r, full_r and almost_full_r are registered, computed from the next count, and change on the same edge as count_r.

Simultaneous push and pop:
- Both occur in the same cycle.
- A full FIFO with pop_cnt > 0 still rejects any push with k > 0 that cycle; the freed space is usable the next cycle.

Wrap-around:
- A multi-entry push or pop spanning index D-1 to 0 is legal and must preserve order.

Test Plan:
- Reset, then push_vld=4'b1010 with data (port1=0xA1, port3=0xA3); next cycle pop_cnt=2 -> count_r=2 after the push edge; one cycle after the pop, pop_valid_r=2'b11 with lane0=0xA1, lane1=0xA3; then count_r=0, empty_r=1.
- Push 4 entries per cycle for 4 cycles (values 0..15) -> full_r=1 and count_r=16; almost_full_r rises at the edge where count reaches 12; a further push_vld=4'b0001 -> push_ovf_r pulses for 1 cycle and count_r stays 16.
- FIFO at 15 entries, push_vld=4'b0011 -> whole push rejected, push_ovf_r=1, count_r=15; same cycle with pop_cnt=2 -> count_r=13, pop data = oldest two entries.
- count_r=1 with pop_cnt=2 -> pop_valid_r=2'b01, count_r=0, empty_r=1.
- Wrap: advance pointers to rd=wr=14, push 4 entries 0x10..0x13, then pop 2 per cycle twice -> outputs 0x10,0x11 then 0x12,0x13, in order.
- Assert rst asynchronously mid-cycle with count_r=9 and pop_valid_r=2'b11 -> outputs clear immediately without a clock edge; after release, empty_r=1, and a push of 0x55 on port0 then pop_cnt=1 returns 0x55.
